// File: rtl/can_host_dispatch_pkg.sv
// Shared defaults, FSM state type and small arithmetic helpers for the CAN host dispatcher.
package can_host_dispatch_pkg;

  localparam int unsigned NODES_DEF     = 4;
  localparam int unsigned DATA_SIZE_DEF = 64;
  localparam int unsigned ID_SIZE_DEF   = 11;

  typedef enum logic {CFG, RUN} disp_state_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'b0, v[i]};
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [5:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {11'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/can_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data; DEPTH must be a power of two.
module can_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push, w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/can_host_dispatch.sv
// Host-side CAN dispatcher: fans FIFO packets out to requesting nodes and
// round-robin collects received node data onto a single downstream stream.
module can_host_dispatch
  import can_host_dispatch_pkg::*;
#(
  parameter int unsigned        NODES     = NODES_DEF,
  parameter int unsigned        DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned        ID_SIZE   = ID_SIZE_DEF,
  parameter int unsigned        DEPTH     = 4,
  parameter logic [ID_SIZE-1:0] RETRY_ID  = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [DATA_SIZE-1:0]         i_in_packet,
  input  logic                         i_id_load,
  input  logic [NODES*ID_SIZE-1:0]     i_id_table,
  input  logic [NODES-1:0]             i_data_in_req,
  input  logic [NODES-1:0]             i_retransmit,
  input  logic [NODES-1:0]             i_data_out_req,
  input  logic [NODES*DATA_SIZE-1:0]   i_rx_packet,
  output logic [NODES*DATA_SIZE-1:0]   o_in_packet,
  output logic [NODES*ID_SIZE-1:0]     o_tx_id,
  output logic [NODES*ID_SIZE-1:0]     o_rx_id,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [DATA_SIZE-1:0]         o_out_packet,
  output logic [15:0]                  o_retry_count,
  output logic [15:0]                  o_rx_drop_count
);

  localparam int unsigned PW = (NODES > 1) ? $clog2(NODES) : 1;

  disp_state_t                r_state, w_state_next;
  logic [NODES*ID_SIZE-1:0]   r_id_table, r_tx_id;
  logic [NODES*DATA_SIZE-1:0] r_in_packet;
  logic [NODES-1:0]           r_req_pend, w_req_pend_next;
  logic [NODES-1:0]           r_rx_pend, w_rx_pend_next, w_drain_mask, w_drop, w_capture;
  logic [DATA_SIZE-1:0]       r_rx_buf [NODES];
  logic [PW-1:0]              r_rr_ptr, w_grant, w_ptr_next;
  logic                       w_grant_valid, w_load;
  logic                       r_out_valid;
  logic [DATA_SIZE-1:0]       r_out_packet, w_fifo_data;
  logic [15:0]                r_retry_count, r_rx_drop_count;
  logic                       w_push, w_pop, w_full, w_empty, w_dispatch;

  can_sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (i_in_packet),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= CFG;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CFG:     if (i_id_load) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = CFG;
    endcase
  end

  assign o_in_ready = (r_state == RUN) && !w_full;
  assign w_push     = i_in_valid && o_in_ready;
  // Any retransmit strobe takes priority and stalls dispatch for the cycle.
  assign w_dispatch = (|r_req_pend) && !(|i_retransmit) && !w_empty;
  assign w_pop      = w_dispatch;
  assign w_req_pend_next = w_dispatch ? i_data_in_req : (r_req_pend | i_data_in_req);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_id_table    <= '0;
      r_tx_id       <= '0;
      r_in_packet   <= '0;
      r_req_pend    <= '0;
      r_retry_count <= '0;
    end else begin
      if (i_id_load) r_id_table <= i_id_table;
      r_req_pend    <= w_req_pend_next;
      r_retry_count <= sat_add16(r_retry_count, popcount32(32'(i_retransmit)));
      for (int i = 0; i < NODES; i++) begin
        if (i_retransmit[i]) begin
          r_tx_id[i*ID_SIZE +: ID_SIZE] <= RETRY_ID;
        end else if (w_dispatch && r_req_pend[i]) begin
          r_in_packet[i*DATA_SIZE +: DATA_SIZE] <= w_fifo_data;
          r_tx_id[i*ID_SIZE +: ID_SIZE]         <= r_id_table[i*ID_SIZE +: ID_SIZE];
        end
      end
    end
  end

  // Each transmitter is heard by its ring successor.
  for (genvar g = 0; g < NODES; g++) begin : g_ring
    assign o_rx_id[((g+1)%NODES)*ID_SIZE +: ID_SIZE] = r_tx_id[g*ID_SIZE +: ID_SIZE];
  end

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    for (int k = 0; k < NODES; k++) begin
      if (!w_grant_valid && r_rx_pend[(int'(r_rr_ptr) + k) % NODES]) begin
        w_grant_valid = 1'b1;
        w_grant       = PW'((int'(r_rr_ptr) + k) % NODES);
      end
    end
  end

  assign w_ptr_next     = (w_grant == PW'(NODES-1)) ? '0 : w_grant + PW'(1);
  assign w_load         = !r_out_valid || i_out_ready;
  assign w_drain_mask   = (w_load && w_grant_valid) ? (NODES'(1) << w_grant) : '0;
  assign w_drop         = i_data_out_req & r_rx_pend & ~w_drain_mask;
  assign w_capture      = i_data_out_req & ~w_drop;
  assign w_rx_pend_next = (r_rx_pend & ~w_drain_mask) | i_data_out_req;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_pend       <= '0;
      r_rr_ptr        <= '0;
      r_out_valid     <= 1'b0;
      r_out_packet    <= '0;
      r_rx_drop_count <= '0;
    end else begin
      r_rx_pend       <= w_rx_pend_next;
      r_rx_drop_count <= sat_add16(r_rx_drop_count, popcount32(32'(w_drop)));
      if (w_load) begin
        if (w_grant_valid) begin
          r_out_valid  <= 1'b1;
          r_out_packet <= r_rx_buf[w_grant];
          r_rr_ptr     <= w_ptr_next;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NODES; i++) begin
      if (w_capture[i]) r_rx_buf[i] <= i_rx_packet[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  assign o_in_packet     = r_in_packet;
  assign o_tx_id         = r_tx_id;
  assign o_out_valid     = r_out_valid;
  assign o_out_packet    = r_out_packet;
  assign o_retry_count   = r_retry_count;
  assign o_rx_drop_count = r_rx_drop_count;

endmodule

// File: doc/can_host_dispatch.md
CAN_HOST_DISPATCH -- requirements
Module: can_host_dispatch

Interface
REQ-001 Parameter NODES, default 4, number of CAN nodes served (legal range 2..32).
REQ-002 Parameter DATA_SIZE, default 64, packet width in bits.
REQ-003 Parameter ID_SIZE, default 11, identifier width.
REQ-004 Parameter DEPTH, default 4, input FIFO depth (power of two, at least 2).
REQ-005 Parameter RETRY_ID, default 0, high-priority identifier used for retransmission.
REQ-006 clock  in  1  single clock; all state changes on posedge clock.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 in_valid/in_ready  in/out  1/1  upstream packet handshake.
REQ-009 in_packet  in  DATA_SIZE  upstream packet.
REQ-010 id_load  in  1  loads id_table into the internal ID table.
REQ-011 id_table  in  NODES*ID_SIZE  per-node transmit IDs; node i occupies slice [i*ID_SIZE +: ID_SIZE].
REQ-012 data_in_req, Retransmit, data_out_req  in  NODES each  per-node request strobes.
REQ-013 Rx_packet  in  NODES*DATA_SIZE  per-node received data.
REQ-014 In_packet  out  NODES*DATA_SIZE  per-node transmit data.
REQ-015 Tx_ID, Rx_ID  out  NODES*ID_SIZE each  per-node identifiers and acceptance filters.
REQ-016 out_valid/out_ready  out/in  1/1  downstream handshake; out_packet  out  DATA_SIZE  downstream data.
REQ-017 retry_count, rx_drop_count  out  16 each  saturating statistics counters.

Function
REQ-018 The FSM SHALL have two states: CFG (reset state) and RUN; the only transition is CFG->RUN on id_load, and id_load while in RUN SHALL reload the ID table without changing state.
REQ-019 in_ready SHALL be 1 only in RUN with the FIFO not full; a push is accepted on in_valid&&in_ready, and a simultaneous push and pop when full SHALL be refused (in_ready stays 0).
REQ-020 A data_in_req[i] pulse SHALL set req_pend[i], which holds until served.
REQ-021 Dispatch SHALL occur in a cycle where req_pend is nonzero, Retransmit is all zero, and the FIFO is not empty; in that cycle the block pops one packet, and the next cycle every pending node i sees In_packet[i] equal to the packet and Tx_ID[i] equal to ID[i], with req_pend cleared (latency 1 cycle).
REQ-022 While the FIFO is empty, requests SHALL stay pending with no timeout.
REQ-023 Retransmit[i] SHALL set Tx_ID[i] to RETRY_ID the next cycle, leave In_packet[i] unchanged, increment retry_count once per asserted bit per cycle (saturating at 16'hFFFF), and block all dispatch that cycle.
REQ-024 Rx_ID[(i+1) mod NODES] SHALL equal Tx_ID[i] at all times (combinational ring pairing), so that every transmitter has one receiver.
REQ-025 data_out_req[i] SHALL capture Rx_packet[i] into rx_buf[i] and set rx_pend[i].
REQ-026 If rx_pend[i] is already set and not being drained in the same cycle, the new data SHALL be dropped and rx_drop_count incremented (saturating).
REQ-027 A round-robin arbiter SHALL pick the lowest pending index at or after the pointer (wrapping past NODES-1) and load the output register when out_valid is 0 or out_ready is 1; the pointer then advances to grant+1 mod NODES.
REQ-028 out_packet SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 After reset, all outputs SHALL be 0, except Tx_ID and Rx_ID, which are 0 because the ID table resets to 0.

Reset
REQ-030 Reset SHALL asynchronously clear the FSM to CFG, the FIFO to empty, req_pend, rx_pend, the RR pointer, both counters, the ID table, and all output registers; reset asserted mid-transfer SHALL discard every in-flight packet.

Structure
REQ-031 def.pkg SHALL hold the defaults for NODES, DATA_SIZE and ID_SIZE, plus the enum disp_state_t {CFG, RUN}.
REQ-032 The input FIFO SHALL be a sub-module can_sync_fifo (parameters WIDTH, DEPTH; outputs full and empty).

Verification
REQ-033 id_load with IDs {0x10,0x20,0x30,0x40}, push 0xA5 packet, pulse data_in_req=4'b0101 -> next cycle In_packet[0]=In_packet[2]=0xA5, Tx_ID[0]=0x10, Tx_ID[2]=0x30, Rx_ID[1]=0x10, Rx_ID[3]=0x30.
REQ-034 Push 4 packets with no requests -> in_ready=0 after the 4th; a 5th in_valid is not accepted; one dispatch -> in_ready=1 next cycle.
REQ-035 Retransmit[1]=1 alongside data_in_req[0] -> Tx_ID[1]=0, no pop, retry_count=1; the following cycle node 0 is dispatched.
REQ-036 data_out_req=4'b1111 with out_ready=1 -> out_packet sequence is nodes 0,1,2,3; hold out_ready=0 -> output stable; repeat data_out_req[2] while pending -> rx_drop_count=1.
REQ-037 Assert reset mid-dispatch with FIFO holding 3 entries -> all outputs 0, state CFG, in_ready=0 until id_load.
